// File: rtl/input_conditioner.sv
// Front-end conditioning for the board keys and switches: synchronizers,
// per-key debounce/auto-repeat FSMs, and a clamped boat-count register.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter logic [3:0]  REPEAT_EN       = 4'b0011
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       sw_direction,
    input  logic [2:0] sw_amount,
    output logic       move_h,
    output logic       move_v,
    output logic       fire,
    output logic       place_boat,
    output logic       direction,
    output logic [2:0] amount_boats
);

    localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int          CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        RELEASE_DB,
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT
    } key_state_t;

    function automatic logic [2:0] clamp_amount(input logic [2:0] raw);
        if (raw == 3'd0) begin
            return 3'd1;
        end else if (raw > 3'd5) begin
            return 3'd5;
        end else begin
            return raw;
        end
    endfunction

    logic [3:0] key_sync_p0;
    logic [3:0] key_sync_p1;
    logic       sw_dir_p0;
    logic       sw_dir_p1;
    logic [2:0] sw_amt_p0;
    logic [2:0] sw_amt_p1;
    logic [3:0] pressed;
    logic [3:0] pulse;

    // Stage p0/p1: two-flop synchronizers; keys idle high, switches idle low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_sync_p0  <= 4'hF;
            key_sync_p1  <= 4'hF;
            sw_dir_p0    <= 1'b0;
            sw_dir_p1    <= 1'b0;
            sw_amt_p0    <= 3'd0;
            sw_amt_p1    <= 3'd0;
            direction    <= 1'b0;
            amount_boats <= 3'd1;
        end else begin
            key_sync_p0  <= key_n;
            key_sync_p1  <= key_sync_p0;
            sw_dir_p0    <= sw_direction;
            sw_dir_p1    <= sw_dir_p0;
            sw_amt_p0    <= sw_amount;
            sw_amt_p1    <= sw_amt_p0;
            direction    <= sw_dir_p1;
            amount_boats <= clamp_amount(sw_amt_p1);
        end
    end

    assign pressed = ~key_sync_p1;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_state_t       state_q;
        key_state_t       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             pulse_q;
        logic             pulse_d;

        // Stage p2: debounce/repeat state and the registered pulse
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q <= RELEASE_DB;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            case (state_q)
                // A bounce while releasing goes back to HELD so it cannot re-fire
                RELEASE_DB: begin
                    if (pressed[k]) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                IDLE: begin
                    if (pressed[k]) begin
                        state_d = PRESS_DB;
                        cnt_d   = '0;
                    end
                end
                PRESS_DB: begin
                    if (!pressed[k]) begin
                        state_d = IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        pulse_d = 1'b1;
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!pressed[k]) begin
                        state_d = RELEASE_DB;
                        cnt_d   = '0;
                    end else if (REPEAT_EN[k]) begin
                        if (cnt_q == DLY_LAST) begin
                            pulse_d = 1'b1;
                            state_d = REPEAT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (!pressed[k]) begin
                        state_d = RELEASE_DB;
                        cnt_d   = '0;
                    end else if (cnt_q == PER_LAST) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end
            endcase
        end

        assign pulse[k] = pulse_q;
    end

    assign move_h     = pulse[0];
    assign move_v     = pulse[1];
    assign fire       = pulse[2];
    assign place_boat = pulse[3];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a run-length key model predicts
// pulses and switch outputs; a monitor compares whatever the DUT presents.
module tb_input_conditioner;

    localparam int         D   = 8;
    localparam int         R   = 20;
    localparam int         P   = 6;
    localparam logic [3:0] REN = 4'b0011;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       sw_direction = 1'b0;
    logic [2:0] sw_amount = 3'd0;
    logic       move_h, move_v, fire, place_boat, direction;
    logic [2:0] amount_boats;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (R),
        .REPEAT_PERIOD  (P),
        .REPEAT_EN      (REN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_n       (key_n),
        .sw_direction(sw_direction),
        .sw_amount   (sw_amount),
        .move_h      (move_h),
        .move_v      (move_v),
        .fire        (fire),
        .place_boat  (place_boat),
        .direction   (direction),
        .amount_boats(amount_boats)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } ev_t;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    ev_t sb[$];
    ev_t obs[$];

    // reference model state: per key "accepted down" flag and run lengths of p
    bit         down [4];
    int         run  [4];
    int         zrun [4];
    logic [3:0] kh0, kh1;
    logic       dh0, dh1, exp_dir;
    logic [2:0] ah0, ah1, exp_amt;

    function automatic logic [2:0] ref_clamp(input logic [2:0] a);
        return (a == 3'd0) ? 3'd1 : ((a > 3'd5) ? 3'd5 : a);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            down[k] = 1'b1;
            zrun[k] = 1;
            run[k]  = 0;
        end
        kh0 = 4'hF; kh1 = 4'hF;
        dh0 = 1'b0; dh1 = 1'b0; exp_dir = 1'b0;
        ah0 = 3'd0; ah1 = 3'd0; exp_amt = 3'd1;
    endtask

    function automatic int pulse_nth(input int k, input int from, input int n);
        int c = 0;
        foreach (obs[i]) begin
            if (obs[i].cyc >= from && obs[i].mask[k]) begin
                if (c == n) return obs[i].cyc;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic int pulse_count(input int k, input int from);
        int c = 0;
        foreach (obs[i]) if (obs[i].cyc >= from && obs[i].mask[k]) c++;
        return c;
    endfunction

    // model: the key value seen by the debouncer at edge t is the pin sampled at t-2
    initial begin : model
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_reset();
                sb.delete();
            end else begin
                logic [3:0] m;
                ev_t        e;
                m = 4'b0;
                cyc++;
                for (int k = 0; k < 4; k++) begin
                    logic s;
                    s = !kh1[k];
                    if (!down[k]) begin
                        if (s) begin
                            run[k]++;
                            if (run[k] == D + 1) begin
                                m[k] = 1'b1; down[k] = 1'b1; run[k] = 0; zrun[k] = 0;
                            end
                        end else begin
                            run[k] = 0;
                        end
                    end else if (s) begin
                        if (zrun[k] > 0) begin
                            zrun[k] = 0; run[k] = 0;
                        end else begin
                            run[k]++;
                            if (REN[k] && run[k] >= R && ((run[k] - R) % P) == 0) m[k] = 1'b1;
                        end
                    end else begin
                        zrun[k]++;
                        if (zrun[k] == D + 1) begin
                            down[k] = 1'b0; run[k] = 0; zrun[k] = 0;
                        end
                    end
                end
                kh1 = kh0; kh0 = key_n;
                exp_dir = dh1; dh1 = dh0; dh0 = sw_direction;
                exp_amt = ref_clamp(ah1); ah1 = ah0; ah0 = sw_amount;
                if (m != 4'b0) begin
                    e.cyc = cyc; e.mask = m;
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                logic [3:0] act;
                ev_t        e;
                act = {place_boat, fire, move_v, move_h};
                check("direction", int'(direction), int'(exp_dir));
                check("amount_boats", int'(amount_boats), int'(exp_amt));
                if (act != 4'b0) begin
                    e.cyc = cyc; e.mask = act;
                    obs.push_back(e);
                end
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    tests++;
                    if (e.cyc != cyc || act != e.mask) begin
                        fails++;
                        $display("FAIL pulse: cycle %0d got mask %b, expected mask %b at cycle %0d",
                                 cyc, act, e.mask, e.cyc);
                    end
                end else if (act != 4'b0) begin
                    tests++;
                    fails++;
                    $display("FAIL pulse: cycle %0d got unexpected mask %b, expected none", cyc, act);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin : stimulus
        int         t0, t1;
        int         hold [4];
        int         offs [7];
        logic [2:0] amt_set [3];
        logic [2:0] amt_exp [3];
        logic [2:0] amt_old;
        offs    = '{10, 30, 36, 42, 48, 54, 60};
        amt_set = '{3'd7, 3'd0, 3'd3};
        amt_exp = '{3'd5, 3'd1, 3'd3};

        // reset state
        wait_neg(2);
        #1;
        check("rst_pulses", int'({place_boat, fire, move_v, move_h}), 0);
        check("rst_direction", int'(direction), 0);
        check("rst_amount", int'(amount_boats), 1);
        wait_neg(1);
        reset = 1'b1;
        wait_neg(12);

        // clean press on fire
        t0 = cyc + 1;
        key_n[2] = 1'b0;
        wait_neg(40);
        key_n[2] = 1'b1;
        wait_neg(25);
        check("press_fire_count", pulse_count(2, t0), 1);
        check("press_fire_latency", pulse_nth(2, t0, 0) - t0, 10);

        // bounce on move_h
        t0 = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            key_n[0] = 1'b0;
            wait_neg(3);
            key_n[0] = 1'b1;
            wait_neg(3);
        end
        wait_neg(20);
        check("bounce_move_h_count", pulse_count(0, t0), 0);

        // auto-repeat on move_v, fire does not repeat
        t0 = cyc + 1;
        key_n[1] = 1'b0;
        key_n[2] = 1'b0;
        wait_neg(60);
        key_n[1] = 1'b1;
        key_n[2] = 1'b1;
        wait_neg(25);
        check("repeat_move_v_count", pulse_count(1, t0), 7);
        for (int i = 0; i < 7; i++) check("repeat_move_v_offset", pulse_nth(1, t0, i) - t0, offs[i]);
        check("repeat_fire_count", pulse_count(2, t0), 1);

        // simultaneous move_h and place_boat
        t0 = cyc + 1;
        key_n = 4'b0110;
        wait_neg(15);
        key_n = 4'hF;
        wait_neg(20);
        check("simul_move_h_latency", pulse_nth(0, t0, 0) - t0, 10);
        check("simul_place_latency", pulse_nth(3, t0, 0) - t0, 10);

        // clamp and switch latency
        for (int i = 0; i < 3; i++) begin
            amt_old = amount_boats;
            sw_amount = amt_set[i];
            @(posedge clock); @(posedge clock); #1;
            check("amount_not_early", int'(amount_boats), int'(amt_old));
            @(posedge clock); #1;
            check("amount_clamped", int'(amount_boats), int'(amt_exp[i]));
            wait_neg(1);
        end
        sw_direction = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        check("direction_not_early", int'(direction), 0);
        @(posedge clock); #1;
        check("direction_set", int'(direction), 1);
        wait_neg(1);

        // randomized keys and switches, checked by the scoreboard
        for (int k = 0; k < 4; k++) hold[k] = $urandom_range(1, 50);
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 4; k++) begin
                hold[k]--;
                if (hold[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 60);
                end
            end
            if ($urandom_range(0, 40) == 0) sw_amount = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 60) == 0) sw_direction = ~sw_direction;
            wait_neg(1);
        end
        key_n = 4'hF;
        sw_amount = 3'd4;
        wait_neg(60);

        // reset while a pulse is high cancels it
        t0 = cyc + 1;
        key_n[1] = 1'b0;
        wait_neg(11);
        #1;
        check("pre_reset_move_v", int'(move_v), 1);
        #1;
        reset = 1'b0;
        #1;
        check("reset_cancels_pulse", int'({place_boat, fire, move_v, move_h}), 0);
        check("reset_amount", int'(amount_boats), 1);
        key_n[1] = 1'b1;
        wait_neg(3);
        reset = 1'b1;
        wait_neg(15);

        // reset 5 cycles into a debounce, fire and move_v held through deassertion
        key_n[0] = 1'b0;
        key_n[2] = 1'b0;
        wait_neg(5);
        #1;
        reset = 1'b0;
        #1;
        check("reset_mid_debounce_pulses", int'({place_boat, fire, move_v, move_h}), 0);
        check("reset_mid_debounce_amount", int'(amount_boats), 1);
        key_n[0] = 1'b1;
        key_n[1] = 1'b0;
        wait_neg(3);
        reset = 1'b1;
        t0 = cyc + 1;
        wait_neg(40);
        check("held_reset_fire_count", pulse_count(2, t0), 0);
        check("held_reset_move_h_count", pulse_count(0, t0), 0);
        check("held_reset_move_v_first", pulse_nth(1, t0, 0) - t0, 2 + R);
        key_n = 4'hF;
        wait_neg(20);
        t1 = cyc + 1;
        key_n[2] = 1'b0;
        wait_neg(15);
        key_n[2] = 1'b1;
        wait_neg(20);
        check("repress_fire_count", pulse_count(2, t1), 1);
        check("repress_fire_latency", pulse_nth(2, t1, 0) - t1, 10);

        wait_neg(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
